// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 panel scanner: state encoding and width helpers.
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CLOCK   = 3'd2,
        ST_BLANK   = 3'd3,
        ST_LATCH   = 3'd4,
        ST_DISPLAY = 3'd5
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >>> 1;
        end
        return result;
    endfunction

    // A one-plane panel still needs a one-bit plane port.
    function automatic int plane_w(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// Down-counting display timer: load a tick count, count while enabled, pulse done on the last tick.
module hub75_oe_timer #(
    parameter int W = 4
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = enable && (count == W'(1));

endmodule

// File: rtl/hub75_scanner.sv
// HUB75 panel scanner: fetches and shifts one row per bit plane, then latches and shows it
// for a binary-weighted time, walking planes inside rows.
//
// state   | meaning
// IDLE    | stopped, waiting for run
// FETCH   | pix_req high until pix_valid delivers the column's data
// CLOCK   | clk_pixel high for one cycle
// BLANK   | OE off, displayed row address updated
// LATCH   | row_latch pulse
// DISPLAY | OE gated by brightness_enable for OE_BASE_TICKS<<plane cycles
module hub75_scanner
    import hub75_pkg::*;
#(
    parameter int COLS          = 64,
    parameter int ROW_ADDR_W    = 4,
    parameter int DEPTH         = 6,
    parameter int OE_BASE_TICKS = 8
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic                         run,
    input  logic [DEPTH-1:0]             brightness_enable,
    output logic                         pix_req,
    input  logic                         pix_valid,
    input  logic [2:0]                   rgb_top,
    input  logic [2:0]                   rgb_bot,
    output logic [clog2(COLS)-1:0]       column_address,
    output logic [ROW_ADDR_W-1:0]        row_address,
    output logic [plane_w(DEPTH)-1:0]    plane,
    output logic [2:0]                   rgb1,
    output logic [2:0]                   rgb2,
    output logic                         clk_pixel,
    output logic                         row_latch,
    output logic                         output_enable,
    output logic [ROW_ADDR_W-1:0]        row_address_active,
    output logic                         frame_start
);

    localparam int COL_W   = clog2(COLS);
    localparam int PLANE_W = plane_w(DEPTH);
    localparam int OE_W    = clog2(OE_BASE_TICKS << (DEPTH - 1)) + 1;

    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic              fs_nxt;
    logic              oe_done;
    logic              last_col;
    logic              last_plane;
    logic              last_row;
    logic [OE_W-1:0]   oe_ticks;

    assign last_col   = (column_address == LAST_COL);
    assign last_plane = (plane == LAST_PLANE);
    assign last_row   = (row_address == '1);
    assign oe_ticks   = OE_W'(OE_BASE_TICKS) << plane;

    hub75_oe_timer #(
        .W (OE_W)
    ) u_oe_timer (
        .clk_in     (clk_in),
        .reset      (reset),
        .load       (state == ST_LATCH),
        .load_value (oe_ticks),
        .enable     (state == ST_DISPLAY),
        .done       (oe_done)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // frame_start is flagged on the transition into the first FETCH of row 0 plane 0.
    always_comb begin
        state_nxt = state;
        fs_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt = ST_FETCH;
                    fs_nxt    = (row_address == '0) && (plane == '0);
                end
            end
            ST_FETCH: begin
                if (pix_valid) begin
                    state_nxt = ST_CLOCK;
                end
            end
            ST_CLOCK:   state_nxt = last_col ? ST_BLANK : ST_FETCH;
            ST_BLANK:   state_nxt = ST_LATCH;
            ST_LATCH:   state_nxt = ST_DISPLAY;
            ST_DISPLAY: begin
                if (oe_done) begin
                    state_nxt = run ? ST_FETCH : ST_IDLE;
                    fs_nxt    = run && last_plane && last_row;
                end
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            column_address     <= '0;
            row_address        <= '0;
            plane              <= '0;
            rgb1               <= '0;
            rgb2               <= '0;
            row_address_active <= '0;
            frame_start        <= 1'b0;
        end else begin
            frame_start <= fs_nxt;
            if ((state == ST_FETCH) && pix_valid) begin
                rgb1 <= rgb_top;
                rgb2 <= rgb_bot;
            end
            if (state == ST_CLOCK) begin
                column_address <= last_col ? '0 : column_address + COL_W'(1);
            end
            if (state == ST_BLANK) begin
                row_address_active <= row_address;
            end
            if ((state == ST_DISPLAY) && oe_done) begin
                if (last_plane) begin
                    plane       <= '0;
                    row_address <= row_address + ROW_ADDR_W'(1);
                end else begin
                    plane <= plane + PLANE_W'(1);
                end
            end
        end
    end

    assign pix_req       = (state == ST_FETCH);
    assign clk_pixel     = (state == ST_CLOCK);
    assign row_latch     = (state == ST_LATCH);
    assign output_enable = (state == ST_DISPLAY) && brightness_enable[plane];

endmodule

// File: doc/hub75_scanner.md
HUB75_SCANNER -- requirements
Module: hub75_scanner

Interface
REQ-001 SHALL have parameter COLS, default 64, columns shifted per row per plane (>=2).
REQ-002 SHALL have parameter ROW_ADDR_W, default 4, row address width; rows scanned = 2**ROW_ADDR_W.
REQ-003 SHALL have parameter DEPTH, default 6, bit planes per pixel channel (1..8).
REQ-004 SHALL have parameter OE_BASE_TICKS, default 8, clk_in cycles of OE for plane 0 (>=1).
REQ-005 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port run  input  1  level enable for scanning.
REQ-008 SHALL have port brightness_enable  input  DEPTH  per-plane OE gate.
REQ-009 SHALL have port pix_req  output  1  pixel fetch request.
REQ-010 SHALL have port pix_valid  input  1  fetch response; rgb_top/rgb_bot valid this cycle.
REQ-011 SHALL have port rgb_top, rgb_bot  input  3 each  plane bits for upper and lower half.
REQ-012 SHALL have port column_address  output  clog2(COLS)  column being fetched.
REQ-013 SHALL have port row_address  output  ROW_ADDR_W  row being shifted.
REQ-014 SHALL have port plane  output  clog2(DEPTH) (min 1)  plane being shifted.
REQ-015 SHALL have port rgb1, rgb2  output  3 each  panel data lines.
REQ-016 SHALL have ports clk_pixel, row_latch, output_enable  output  1 each  panel controls (output_enable active-high).
REQ-017 SHALL have port row_address_active  output  ROW_ADDR_W  row currently displayed.
REQ-018 SHALL have port frame_start  output  1  one-cycle pulse at start of row 0 plane 0.

Function
REQ-019 SHALL sequence states IDLE, FETCH, CLOCK, BLANK, LATCH, DISPLAY.
REQ-020 IDLE SHALL move to FETCH when run=1; scan order SHALL be planes 0..DEPTH-1 inside rows 0..2**ROW_ADDR_W-1.
REQ-021 FETCH SHALL hold pix_req=1 with stable column_address/row_address/plane until pix_valid=1; wait is unbounded.
REQ-022 On pix_valid, rgb1/rgb2 SHALL register rgb_top/rgb_bot with clk_pixel=0, then CLOCK SHALL drive clk_pixel=1 for exactly one cycle; pix_valid outside FETCH SHALL be ignored.
REQ-023 After CLOCK of column COLS-1 SHALL enter BLANK; otherwise column_address increments and returns to FETCH.
REQ-024 BLANK SHALL last one cycle with output_enable=0 and load row_address_active from row_address.
REQ-025 LATCH SHALL assert row_latch for exactly one cycle with output_enable=0.
REQ-026 DISPLAY SHALL last OE_BASE_TICKS<<plane cycles; output_enable=brightness_enable[plane] throughout, otherwise 0; duration SHALL NOT depend on brightness_enable.
REQ-027 OE counter width SHALL be clog2(OE_BASE_TICKS<<(DEPTH-1))+1, no overflow.
REQ-028 After DISPLAY, plane increments; at DEPTH-1 plane wraps to 0 and row increments; last row wraps to 0 and frame_start pulses on the first FETCH of the new frame.
REQ-029 If run=0 at end of DISPLAY, SHALL enter IDLE with output_enable=0 and counters retained; run deassertion mid-plane SHALL NOT truncate the plane.
REQ-030 output_enable SHALL be 0 in every state except DISPLAY; row_latch and clk_pixel SHALL never be high simultaneously.

Reset
REQ-031 reset=0 SHALL immediately force IDLE and all outputs, column/row/plane/OE counters to 0.
REQ-032 Reset mid-DISPLAY SHALL drop output_enable asynchronously in the same instant.
REQ-033 First frame_start after reset release SHALL occur on the first FETCH with run=1.

Structure
REQ-034 State encoding and a clog2 helper SHALL live in shared package hub75_pkg.
REQ-035 The DISPLAY duration counter SHALL be sub-module hub75_oe_timer (load value, count down, done pulse).

Verification (COLS=4, ROW_ADDR_W=1, DEPTH=2, OE_BASE_TICKS=3)
REQ-036 run=1, pix_valid tied 1, brightness_enable=2'b11 -> 4 clk_pixel pulses, latch, OE 3 cycles (plane0) then 6 cycles (plane1), frame_start every 2 rows x 2 planes.
REQ-037 pix_valid delayed 5 cycles on column 2 -> pix_req held 5 cycles, address stable, no clk_pixel until data.
REQ-038 brightness_enable=2'b01 -> plane1 DISPLAY 6 cycles with output_enable=0, frame period unchanged.
REQ-039 run dropped mid-FETCH of row1 plane1 -> plane completes, OE 6 cycles, IDLE, pix_req=0.
REQ-040 reset=0 mid-DISPLAY -> output_enable=0 same instant, all outputs 0; after release frame_start on row0 plane0.
